counter_updown_param: RTL and testbench

COUNTER_UPDOWN_PARAM -- requirements
Module: counter_updown_param

---
 rtl/counter_updown_param_if.sv | 26 ++
 rtl/counter_updown_param.sv | 144 ++++++++++++++
 tb/tb_counter_updown_param.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_updown_param_if.sv
// Bus bundle for counter_updown_param: the step/mode/load controls coming in
// and the count, direction and boundary flags going out.
// The master side drives the controls; the slave side is the counter itself.
interface counter_updown_param_if #(
    parameter int WIDTH = 3
);
    logic             x;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] state;
    logic             dir;
    logic             at_max;
    logic             at_min;
    logic             turn;

    modport master (
        output x, mode, load, load_val,
        input  state, dir, at_max, at_min, turn
    );

    modport slave (
        input  x, mode, load, load_val,
        output state, dir, at_max, at_min, turn
    );
endinterface

// File: rtl/counter_updown_param.sv
// counter_updown_param: parameterised up/down counter stepped by rising edges
// of x. Modes: bounce between 0 and MAX_VAL, wrap up, wrap down, or hold.
// A synchronous load (clamped to MAX_VAL) overrides a coincident step.
// Optional macro COUNTER_UPDOWN_SYNC_X_EN inserts a 2-flop synchroniser on x,
// stretching the step latency from 2 to 4 clock edges.
module counter_updown_param #(
    parameter int WIDTH   = 3,
    parameter int MAX_VAL = (2 ** WIDTH) - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    counter_updown_param_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_BOUNCE    = 2'b00,
        MODE_WRAP_UP   = 2'b01,
        MODE_WRAP_DOWN = 2'b10,
        MODE_HOLD      = 2'b11
    } modeE;

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_state;
    logic             r_dir;
    logic             r_turn;
    logic             r_xReg;
    logic             r_xTrig;
    logic             w_xIn;
    modeE             w_mode;
    logic [WIDTH-1:0] w_nextState;
    logic             w_nextDir;
    logic             w_nextTurn;

    assign w_mode = modeE'(bus.mode);

`ifdef COUNTER_UPDOWN_SYNC_X_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop synchroniser so an asynchronous x cannot go metastable into the edge detector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.x;
            r_sync2 <= r_sync1;
        end
    end

    assign w_xIn = r_sync2;
`else
    assign w_xIn = bus.x;
`endif

    // Rising-edge detector: r_xTrig is a single-cycle request per low-to-high transition
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xReg  <= 1'b0;
            r_xTrig <= 1'b0;
        end else begin
            r_xReg  <= w_xIn;
            r_xTrig <= w_xIn & ~r_xReg;
        end
    end

    // Next count, direction and turn pulse; load beats a step, hold discards steps
    always_comb begin
        w_nextState = r_state;
        w_nextDir   = r_dir;
        w_nextTurn  = 1'b0;
        if (bus.load) begin
            w_nextState = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
        end else if (r_xTrig) begin
            case (w_mode)
                MODE_BOUNCE: begin
                    if (r_dir) begin
                        if (r_state == MAX_V) begin
                            w_nextState = MAX_V - 1'b1;
                            w_nextDir   = 1'b0;
                            w_nextTurn  = 1'b1;
                        end else begin
                            w_nextState = r_state + 1'b1;
                        end
                    end else begin
                        if (r_state == '0) begin
                            w_nextState = {{(WIDTH-1){1'b0}}, 1'b1};
                            w_nextDir   = 1'b1;
                            w_nextTurn  = 1'b1;
                        end else begin
                            w_nextState = r_state - 1'b1;
                        end
                    end
                    // With only the values 0 and 1 every bounce step lands on a bound
                    if (MAX_VAL == 1) begin
                        w_nextTurn = 1'b1;
                    end
                end
                MODE_WRAP_UP: begin
                    w_nextDir = 1'b1;
                    if (r_state == MAX_V) begin
                        w_nextState = '0;
                        w_nextTurn  = 1'b1;
                    end else begin
                        w_nextState = r_state + 1'b1;
                    end
                end
                MODE_WRAP_DOWN: begin
                    w_nextDir = 1'b0;
                    if (r_state == '0) begin
                        w_nextState = MAX_V;
                        w_nextTurn  = 1'b1;
                    end else begin
                        w_nextState = r_state - 1'b1;
                    end
                end
                default: begin
                    w_nextState = r_state;
                end
            endcase
        end
    end

    // Count/direction/turn registers; reset parks at zero counting up
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= '0;
            r_dir   <= 1'b1;
            r_turn  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_dir   <= w_nextDir;
            r_turn  <= w_nextTurn;
        end
    end

    assign bus.state  = r_state;
    assign bus.dir    = r_dir;
    assign bus.turn   = r_turn;
    assign bus.at_max = (r_state == MAX_V);
    assign bus.at_min = (r_state == '0);

endmodule

// File: tb/tb_counter_updown_param.sv
// Testbench for counter_updown_param: three instances (MAX_VAL 7, 5 and 1,
// all WIDTH 3) share one stimulus stream and are checked against a
// transaction-level model of the counting rules.
module tb_counter_updown_param;

`ifdef COUNTER_UPDOWN_SYNC_X_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic       clk;
    logic       rst;
    logic       x;
    logic [1:0] mode;
    logic       load;
    logic [2:0] loadVal;

    int nCompared;
    int nMismatched;

    int ms[3];
    int md[3];
    int mt[3];
    int mmax[3] = '{7, 5, 1};

    counter_updown_param_if #(.WIDTH(3)) bus7 ();
    counter_updown_param_if #(.WIDTH(3)) bus5 ();
    counter_updown_param_if #(.WIDTH(3)) bus1 ();

    assign bus7.x = x;  assign bus7.mode = mode;  assign bus7.load = load;  assign bus7.load_val = loadVal;
    assign bus5.x = x;  assign bus5.mode = mode;  assign bus5.load = load;  assign bus5.load_val = loadVal;
    assign bus1.x = x;  assign bus1.mode = mode;  assign bus1.load = load;  assign bus1.load_val = loadVal;

    counter_updown_param #(.WIDTH(3), .MAX_VAL(7)) dut7 (.clk(clk), .rst(rst), .bus(bus7));
    counter_updown_param #(.WIDTH(3), .MAX_VAL(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));
    counter_updown_param #(.WIDTH(3), .MAX_VAL(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] observe(input int i);
        case (i)
            0:       return {bus7.state, bus7.dir, bus7.turn, bus7.at_max, bus7.at_min};
            1:       return {bus5.state, bus5.dir, bus5.turn, bus5.at_max, bus5.at_min};
            default: return {bus1.state, bus1.dir, bus1.turn, bus1.at_max, bus1.at_min};
        endcase
    endfunction

    task automatic checkOutput(input string tag);
        logic [6:0] obs;
        logic [6:0] expv;
        for (int i = 0; i < 3; i++) begin
            obs  = observe(i);
            expv = {3'(ms[i]), md[i] != 0, mt[i] != 0, ms[i] == mmax[i], ms[i] == 0};
            nCompared++;
            assert (obs === expv) else begin
                nMismatched++;
                $error("[TB] FAIL %s max%0d: state/dir/turn/atmax/atmin got %b want %b",
                       tag, mmax[i], obs, expv);
            end
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            ms[i] = 0; md[i] = 1; mt[i] = 0;
        end
    endtask

    task automatic modelLoad(input int lv);
        for (int i = 0; i < 3; i++) ms[i] = (lv < mmax[i]) ? lv : mmax[i];
    endtask

    // One step as seen from outside: move one position, reflecting or wrapping at the ends
    task automatic modelStep();
        int d;
        int t;
        for (int i = 0; i < 3; i++) begin
            case (mode)
                2'b00: begin
                    d = md[i] ? 1 : -1;
                    t = ms[i] + d;
                    if (t < 0 || t > mmax[i]) begin
                        md[i] = !md[i];
                        ms[i] = ms[i] - d;
                        mt[i] = 1;
                    end else begin
                        ms[i] = t;
                    end
                    if (mmax[i] == 1) mt[i] = 1;
                end
                2'b01: begin
                    md[i] = 1;
                    mt[i] = (ms[i] == mmax[i]);
                    ms[i] = (ms[i] + 1) % (mmax[i] + 1);
                end
                2'b10: begin
                    md[i] = 0;
                    mt[i] = (ms[i] == 0);
                    ms[i] = (ms[i] + mmax[i]) % (mmax[i] + 1);
                end
                default: ;
            endcase
        end
    endtask

    // Advance one clock; the turn pulse never outlives a cycle without a step
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) mt[i] = 0;
    endtask

    // Isolated one-cycle x pulse, waiting out the full step latency
    task automatic applyStimulus(input string tag);
        x = 1'b1;
        cycle();
        x = 1'b0;
        repeat (LAT - 1) cycle();
        modelStep();
        checkOutput(tag);
    endtask

    task automatic doLoad(input int lv, input string tag);
        load = 1'b1;
        loadVal = 3'(lv);
        cycle();
        load = 1'b0;
        modelLoad(lv);
        checkOutput(tag);
    endtask

    // Load arriving on the very edge where the pending step would apply
    task automatic doLoadWithTrig(input int lv, input string tag);
        x = 1'b1;
        cycle();
        x = 1'b0;
        repeat (LAT - 2) cycle();
        load = 1'b1;
        loadVal = 3'(lv);
        cycle();
        load = 1'b0;
        modelLoad(lv);
        checkOutput(tag);
        repeat (3) cycle();
        checkOutput({tag, "_nostep"});
    endtask

    // Directed sequence followed by a randomised run
    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst = 1'b0;
        x = 1'b0;
        mode = 2'b00;
        load = 1'b0;
        loadVal = 3'd0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("in_reset");
        rst = 1'b1;
        cycle();
        checkOutput("after_reset");

        for (int k = 0; k < 15; k++) applyStimulus("bounce");
        cycle();
        checkOutput("bounce_idle");

        doLoad(0, "load0");
        mode = 2'b01;
        for (int k = 0; k < 9; k++) applyStimulus("wrap_up");
        doLoad(0, "load0b");
        mode = 2'b10;
        applyStimulus("wrap_down_from0");
        cycle();
        checkOutput("wrap_down_turn_gone");

        mode = 2'b00;
        doLoad(2, "load2");
        x = 1'b1;
        cycle();
        checkOutput("held_e1");
        for (int k = 0; k < LAT - 2; k++) begin
            cycle();
            checkOutput("held_early");
        end
        cycle();
        modelStep();
        checkOutput("held_step");
        for (int k = 0; k < 18; k++) cycle();
        checkOutput("held_single");
        x = 1'b0;
        repeat (LAT + 1) cycle();
        checkOutput("held_release");

        doLoadWithTrig(5, "load_trig5");
        doLoadWithTrig(7, "load_trig7");

        mode = 2'b11;
        for (int k = 0; k < 4; k++) applyStimulus("hold");

        doLoad(7, "load7");
        mode = 2'b10;
        applyStimulus("to6_down");
        mode = 2'b00;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset");
        #1;
        rst = 1'b1;
        repeat (2) cycle();
        checkOutput("post_reset");

        x = 1'b1;
        cycle();
        x = 1'b0;
        repeat (LAT - 2) cycle();
        #2;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        repeat (LAT + 2) cycle();
        checkOutput("pending_lost");

        rst = 1'b0;
        x = 1'b1;
        #1;
        rst = 1'b1;
        modelReset();
        repeat (LAT) cycle();
        modelStep();
        checkOutput("x_high_at_release");
        repeat (5) cycle();
        checkOutput("x_high_single");
        x = 1'b0;
        repeat (LAT) cycle();

        for (int k = 0; k < 60; k++) begin
            int r;
            mode = 2'($urandom_range(0, 3));
            r = int'($urandom_range(0, 9));
            if (r < 6)      applyStimulus("rand_step");
            else if (r < 8) doLoad(int'($urandom_range(0, 7)), "rand_load");
            else            doLoadWithTrig(int'($urandom_range(0, 7)), "rand_load_trig");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
